div_unit: RTL and testbench



---
 rtl/div_pkg.sv | 20 ++
 rtl/div_sign_fix.sv | 12 +
 rtl/div_unit.sv | 142 ++++++++++++++
 tb/tb_div_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the RV32M iterative divider.
package div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_e;

  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate: abs() on operands, sign fix on results.
module div_sign_fix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per clock.
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [XLEN-1:0]   operand_a,
  input  logic [XLEN-1:0]   operand_b,
  input  logic [REG_AW-1:0] rd_in,
  input  logic              kill,
  output logic              busy,
  output logic              done,
  output logic [XLEN-1:0]   result,
  output logic [REG_AW-1:0] rd_out
);

  localparam int unsigned CNT_W = $clog2(XLEN);

  div_state_e        r_state;
  div_op_e           r_op;
  logic              r_sign_a;
  logic              r_sign_b;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_dvd;
  logic [XLEN-1:0]   r_dvs;
  logic [XLEN-1:0]   r_result;
  logic [CNT_W-1:0]  r_cnt;
  logic [REG_AW-1:0] r_rd;

  div_op_e         w_op;
  logic            w_signed;
  logic            w_is_rem_in;
  logic            w_sign_a;
  logic            w_sign_b;
  logic            w_b_zero;
  logic            w_ovf;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic [XLEN-1:0] w_special;

  assign w_op        = div_op_e'(op);
  assign w_signed    = (w_op == DIV) || (w_op == REM);
  assign w_is_rem_in = (w_op == REM) || (w_op == REMU);
  assign w_sign_a    = w_signed & operand_a[XLEN-1];
  assign w_sign_b    = w_signed & operand_b[XLEN-1];
  assign w_b_zero    = (operand_b == '0);
  assign w_ovf       = w_signed && (operand_a == INT_MIN) && (operand_b == '1);

  div_sign_fix #(.W(XLEN)) u_abs_a (.i_val(operand_a), .i_neg(w_sign_a), .o_val(w_abs_a));
  div_sign_fix #(.W(XLEN)) u_abs_b (.i_val(operand_b), .i_neg(w_sign_b), .o_val(w_abs_b));

  always_comb begin
    w_special = DIV_BY_ZERO_Q;
    if (w_b_zero) begin
      w_special = w_is_rem_in ? operand_a : DIV_BY_ZERO_Q;
    end else begin
      w_special = w_is_rem_in ? '0 : INT_MIN;
    end
  end

  // Shifted partial remainder carries one extra bit so the compare never drops a carry.
  logic [XLEN:0]   w_rem_sh;
  logic            w_ge;
  logic [XLEN-1:0] w_rem_new;
  logic [XLEN-1:0] w_quo_new;
  logic            w_is_rem;
  logic            w_neg_res;
  logic [XLEN-1:0] w_fix_in;
  logic [XLEN-1:0] w_fixed;

  assign w_rem_sh  = {r_rem, r_dvd[XLEN-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_dvs});
  assign w_rem_new = w_ge ? (w_rem_sh[XLEN-1:0] - r_dvs) : w_rem_sh[XLEN-1:0];
  assign w_quo_new = {r_dvd[XLEN-2:0], w_ge};
  assign w_is_rem  = (r_op == REM) || (r_op == REMU);
  assign w_neg_res = w_is_rem ? r_sign_a : (r_sign_a ^ r_sign_b);
  assign w_fix_in  = w_is_rem ? w_rem_new : w_quo_new;

  div_sign_fix #(.W(XLEN)) u_fix (.i_val(w_fix_in), .i_neg(w_neg_res), .o_val(w_fixed));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_op     <= DIV;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_rem    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_rd     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start && !kill) begin
            r_op     <= w_op;
            r_rd     <= rd_in;
            r_sign_a <= w_sign_a;
            r_sign_b <= w_sign_b;
            r_dvd    <= w_abs_a;
            r_dvs    <= w_abs_b;
            r_rem    <= '0;
            r_cnt    <= CNT_W'(XLEN - 1);
            if (w_b_zero || w_ovf) begin
              r_result <= w_special;
              r_state  <= DONE;
            end else begin
              r_state  <= CALC;
            end
          end
        end
        CALC: begin
          if (kill) begin
            r_state <= IDLE;
          end else begin
            r_rem <= w_rem_new;
            r_dvd <= w_quo_new;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == '0) begin
              r_result <= w_fixed;
              r_state  <= DONE;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy   = (r_state != IDLE);
  assign done   = (r_state == DONE);
  assign result = r_result;
  assign rd_out = r_rd;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboarded random + directed bench for div_unit against an arithmetic reference.
module tb_div_unit;
  import div_pkg::*;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        kill  = 1'b0;
  logic [1:0]  op    = 2'b00;
  logic [31:0] opa   = '0;
  logic [31:0] opb   = '0;
  logic [4:0]  rd_in = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_checks = 0;
  int n_fail   = 0;
  logic [36:0] sb_q[$];

  always #5 clk = ~clk;

  div_unit #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .operand_a(opa), .operand_b(opb), .rd_in(rd_in), .kill(kill),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    if (y == 32'd0) return o[1] ? x : 32'hFFFF_FFFF;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00:   return 32'(sx / sy);
      2'b01:   return x / y;
      2'b10:   return 32'(sx % sy);
      default: return x % y;
    endcase
  endfunction

  function automatic bit is_special(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    return (y == 32'd0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got result 0x%08h rd %0d, required no done", result, rd_out);
      end else begin
        logic [36:0] e;
        e = sb_q.pop_front();
        check("result", result, e[36:5]);
        check("rd_out", 32'(rd_out), 32'(e[4:0]));
      end
    end
  end

  task automatic wait_idle();
    int i;
    i = 0;
    while (busy && i < 100) begin
      @(posedge clk); #1;
      i++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic do_start(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [4:0] rd, input bit push);
    wait_idle();
    @(negedge clk);
    op = o; opa = x; opb = y; rd_in = rd; start = 1'b1;
    if (push) sb_q.push_back({ref_div(o, x, y), rd});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input logic [4:0] rd);
    int lat;
    bit sp;
    sp = is_special(o, x, y);
    do_start(o, x, y, rd, 1'b1);
    wait_done(lat);
    check("latency", 32'(lat), sp ? 32'd0 : 32'd32);
    if (sp) begin
      @(posedge clk); #1;
      check("busy_after_special", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    repeat (2) @(posedge clk);
    #1;
    check("reset_busy",   32'(busy),   32'd0);
    check("reset_done",   32'(done),   32'd0);
    check("reset_result", result,      32'd0);
    check("reset_rd",     32'(rd_out), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    run_op(DIVU, 32'd100, 32'd7, 5'd5);
    run_op(REMU, 32'd100, 32'd7, 5'd5);
    run_op(DIV,  32'hFFFF_FFF9, 32'd2, 5'd6);
    run_op(REM,  32'hFFFF_FFF9, 32'd2, 5'd7);
    run_op(REM,  32'd7, 32'hFFFF_FFFE, 5'd8);
    run_op(DIVU, 32'd1234, 32'd0, 5'd9);
    run_op(REMU, 32'd1234, 32'd0, 5'd10);
    run_op(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
    run_op(REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
    run_op(DIV,  32'h8000_0000, 32'd1, 5'd13);
    run_op(DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd14);

    // Second start while busy must be ignored.
    do_start(DIVU, 32'd50, 32'd5, 5'd15, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    op = REM; opa = 32'd999; opb = 32'd4; rd_in = 5'd30; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    check("ignored_start_latency", 32'(lat), 32'd22);

    // Kill mid-calculation: no done, idle next cycle.
    do_start(DIVU, 32'd77777, 32'd3, 5'd16, 1'b0);
    repeat (4) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill_busy", 32'(busy), 32'd0);
    check("kill_done", 32'(done), 32'd0);
    repeat (40) @(posedge clk);
    run_op(DIVU, 32'd1000, 32'd10, 5'd17);

    // Kill and start together in IDLE: start dropped.
    @(negedge clk);
    op = DIVU; opa = 32'd5; opb = 32'd1; rd_in = 5'd18; start = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    check("kill_start_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = $urandom_range(1, 15);
        3: ra = 32'h8000_0000;
        4: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(ro, ra, rb, 5'($urandom_range(0, 31)));
    end

    // Asynchronous reset mid-operation.
    do_start(DIVU, 32'hDEAD_BEEF, 32'd3, 5'd19, 1'b0);
    repeat (12) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_busy",   32'(busy),   32'd0);
    check("async_rst_done",   32'(done),   32'd0);
    check("async_rst_result", result,      32'd0);
    check("async_rst_rd",     32'(rd_out), 32'd0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    run_op(DIVU, 32'd9, 32'd3, 5'd20);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
